// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one request in, one or two encoded words out.
// LI expands to LUI (+ ADDI when the low part is nonzero); out-of-range
// requests are replaced by a flagged NOP.
module instr_encoder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_fmt,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  input  logic [4:0]            i_rd,
  input  logic [4:0]            i_rs1,
  input  logic [4:0]            i_rs2,
  input  logic [DATA_WIDTH-1:0] i_imm,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_err,
  output logic                  o_last
);

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_LUI = 7'h37;

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    OUT2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] instr_q, word2_q;
  logic                  err_q, last_q, pend_q;

  logic [DATA_WIDTH-1:0] word1, word2;
  logic                  has2, err;
  logic                  fits12, fits13, fits21;
  logic [19:0]           li_hi;
  logic                  accept, xfer;

  // Range checks: a value fits N signed bits when all bits from N-1 up agree.
  always_comb begin
    fits12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    fits13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    fits21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);
    // (imm + 0x800) >> 12 without a full-width adder: the carry out of the
    // low 12 bits is exactly imm[11].
    li_hi  = i_imm[31:12] + {19'd0, i_imm[11]};
  end

  // Encode the presented request into its first word and optional second word.
  always_comb begin
    word1 = '0;
    word2 = '0;
    has2  = 1'b0;
    err   = 1'b0;
    unique case (i_fmt)
      3'd0: word1 = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      3'd1: begin
        err   = ~fits12;
        word1 = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      3'd2: begin
        err   = ~fits12;
        word1 = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      3'd3: begin
        err   = ~fits13 | i_imm[0];
        word1 = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                 i_imm[4:1], i_imm[11], i_opcode};
      end
      3'd4: begin
        err   = |i_imm[11:0];
        word1 = {i_imm[31:12], i_rd, i_opcode};
      end
      3'd5: begin
        err   = ~fits21 | i_imm[0];
        word1 = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      3'd6: begin
        if (fits12) begin
          word1 = {i_imm[11:0], 5'd0, 3'b000, i_rd, OP_IMM};
        end else begin
          word1 = {li_hi, i_rd, OP_LUI};
          word2 = {i_imm[11:0], i_rd, 3'b000, i_rd, OP_IMM};
          has2  = |i_imm[11:0];
        end
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      word1 = {{(DATA_WIDTH-7){1'b0}}, OP_IMM};
      has2  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake qualifiers.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = i_valid;
        if (i_valid) state_d = OUT;
      end
      OUT: begin
        xfer = i_ready;
        if (i_ready) state_d = pend_q ? OUT2 : IDLE;
      end
      OUT2: begin
        xfer = i_ready;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word registers; held while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q <= '0;
      word2_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (accept) begin
      instr_q <= word1;
      word2_q <= word2;
      err_q   <= err;
      last_q  <= ~has2;
      pend_q  <= has2;
    end else if (xfer && pend_q) begin
      instr_q <= word2_q;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    o_ready = (state_q == IDLE) & ~i_rst;
    o_valid = (state_q != IDLE) & ~i_rst;
    o_instr = i_rst ? '0 : instr_q;
    o_err   = err_q & ~i_rst;
    o_last  = last_q & ~i_rst;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected words,
// a monitor pops and compares on every accepted output word.
module tb_instr_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready_out;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] instr;
  logic        err;
  logic        last;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  instr_encoder #(.DATA_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ready_out),
    .i_fmt   (fmt),
    .i_opcode(opcode),
    .i_funct3(funct3),
    .i_funct7(funct7),
    .i_rd    (rd),
    .i_rs1   (rs1),
    .i_rs2   (rs2),
    .i_imm   (imm),
    .o_valid (valid_out),
    .i_ready (ready_in),
    .o_instr (instr),
    .o_err   (err),
    .o_last  (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic e, input logic l);
    exp_t x;
    x.instr = w;
    x.err   = e;
    x.last  = l;
    sb.push_back(x);
  endtask

  // Compares every word that transfers at the following rising edge.
  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", instr, 32'hDEADBEEF);
        end else begin
          x = sb.pop_front();
          chk("instr", instr, x.instr);
          chk("err", {31'd0, err}, {31'd0, x.err});
          chk("last", {31'd0, last}, {31'd0, x.last});
        end
      end
    end
  endtask

  // Present one request, wait (bounded) for acceptance, check 1-cycle latency.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    int n;
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    valid = 1'b1;
    n = 0;
    while (!ready_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", {31'd0, ready_out}, 32'd1);
    chk("valid_before", {31'd0, valid_out}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    fmt = $urandom_range(0, 7); imm = $urandom;
    chk("latency_valid", {31'd0, valid_out}, 32'd1);
    chk("ready_busy", {31'd0, ready_out}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!ready_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", {31'd0, ready_out}, 32'd1);
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im);
    send(f, op, f3, f7, d, s1, s2, im);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    rst = 1'b1; valid = 1'b0; ready_in = 1'b1;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    fork
      monitor();
    join_none

    // Reset values, with a request presented during reset that must be ignored
    repeat (2) @(posedge clk);
    #1;
    fmt = 3'd1; opcode = 7'h13; rd = 5'd1; imm = 32'd5; valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_last", {31'd0, last}, 32'd0);
    rst = 1'b0; valid = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, ready_out}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_word_after_rst", {31'd0, valid_out}, 32'd0);

    // Format encodings
    push(32'h00500093, 1'b0, 1'b1); req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    push(32'hFE208EE3, 1'b0, 1'b1); req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    push(32'h402081B3, 1'b0, 1'b1); req(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    push(32'hFE20AE23, 1'b0, 1'b1); req(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    push(32'h123452B7, 1'b0, 1'b1); req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    push(32'h001000EF, 1'b0, 1'b1); req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    push(32'h00000013, 1'b0, 1'b1); req(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    // Range boundaries and error substitution
    push(32'h00000013, 1'b1, 1'b1); req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    push(32'h7FF00093, 1'b0, 1'b1); req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
    push(32'h00000013, 1'b1, 1'b1); req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    push(32'h7E000FE3, 1'b0, 1'b1); req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094);
    push(32'h00000013, 1'b1, 1'b1); req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096);
    push(32'h00000013, 1'b1, 1'b1); req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00001001);
    push(32'h00000013, 1'b1, 1'b1); req(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);

    // LI expansions (unused fields driven with junk)
    push(32'hFFF00293, 1'b0, 1'b1); req(3'd6, 7'h7F, 3'd7, 7'h7F, 5'd5, 5'd9, 5'd9, 32'hFFFFFFFF);
    push(32'h123452B7, 1'b0, 1'b1); req(3'd6, 7'h00, 3'd3, 7'h11, 5'd5, 5'd3, 5'd4, 32'h12345000);
    push(32'h123462B7, 1'b0, 1'b0); push(32'hFFF28293, 1'b0, 1'b1);
    req(3'd6, 7'h33, 3'd1, 7'h20, 5'd5, 5'd7, 5'd8, 32'h12345FFF);
    push(32'hFFFFF2B7, 1'b0, 1'b0); push(32'h7FF28293, 1'b0, 1'b1);
    req(3'd6, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFF7FF);

    // Backpressure: three stalled cycles, word held stable
    ready_in = 1'b0;
    push(32'h00500093, 1'b0, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    held = instr;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, valid_out}, 32'd1);
      chk("bp_instr", instr, held);
      chk("bp_ready", {31'd0, ready_out}, 32'd0);
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", {31'd0, valid_out}, 32'd0);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset in OUT2 drops the pending ADDI word
    push(32'h123462B7, 1'b0, 1'b0);
    send(3'd6, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    @(posedge clk); #1;
    chk("out2_valid", {31'd0, valid_out}, 32'd1);
    chk("out2_instr", instr, 32'hFFF28293);
    ready_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_in = 1'b1;
    #1;
    chk("post_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("post_rst_ready", {31'd0, ready_out}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, valid_out}, 32'd0);

    // Back-to-back after recovery still works
    push(32'h001000EF, 1'b0, 1'b1); req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Parameters
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, the instruction and immediate width; only 32 is supported.

Interface
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit: the request fields are valid.
REQ-005 The block SHALL have port o_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port i_fmt, input, 3 bits: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI pseudo-op, 7=reserved.
REQ-007 The block SHALL have ports i_opcode (7 bits), i_funct3 (3 bits) and i_funct7 (7 bits), all inputs: encoding fields.
REQ-008 The block SHALL have ports i_rd, i_rs1 and i_rs2, all inputs, 5 bits each: register indices.
REQ-009 The block SHALL have port i_imm, input, DATA_WIDTH bits: the signed immediate, as a byte offset for B and J formats.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_instr holds a valid word.
REQ-011 The block SHALL have port i_ready, input, 1 bit: the downstream consumer accepts the word.
REQ-012 The block SHALL have port o_instr, output, DATA_WIDTH bits: the encoded RV32I instruction.
REQ-013 The block SHALL have port o_err, output, 1 bit: the current word replaces a rejected request.
REQ-014 The block SHALL have port o_last, output, 1 bit: the current word is the final word of its request.

Function
REQ-015 The block SHALL implement FSM states IDLE, OUT and OUT2, and o_ready SHALL be 1 only in IDLE.
REQ-016 When i_valid and o_ready are both 1, the block SHALL capture the request and encode it, moving to OUT; o_valid SHALL rise on the next cycle, giving a latency of 1.
REQ-017 In OUT or OUT2, o_instr, o_err and o_last SHALL remain stable while i_ready is 0.
REQ-018 In OUT or OUT2, a word SHALL transfer on the cycle o_valid and i_ready are both 1; the block SHALL then go to OUT2 if a second word is pending, otherwise to IDLE.
REQ-019 There SHALL be no same-cycle pass-through; the maximum throughput is one request per 2 cycles.
REQ-020 R format SHALL encode as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-021 I format SHALL encode as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-022 S format SHALL encode as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 B format SHALL encode as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-024 U format SHALL encode as {imm[31:12], rd, opcode}.
REQ-025 J format SHALL encode as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-026 The block SHALL apply these range checks: I and S require -2048..2047; B requires -4096..4094 and even; J requires -1048576..1048574 and even; U requires imm[11:0]=0; fmt 7 always fails.
REQ-027 A failing request SHALL emit a single word 0x00000013 (NOP) with o_err=1 and o_last=1.
REQ-028 For LI, the block SHALL ignore i_opcode, i_funct3, i_funct7, i_rs1 and i_rs2, and the expansion SHALL never fail.
REQ-029 For LI with imm in -2048..2047, the block SHALL emit one word: ADDI rd,x0,imm.
REQ-030 Otherwise, with hi=(imm+0x800)>>12 (modulo 2^32, logical shift) and lo=imm[11:0], the block SHALL emit LUI rd,hi; if lo≠0, it SHALL then emit ADDI rd,rd,lo in OUT2.
REQ-031 o_last SHALL be 1 on the final word of each request only.
REQ-032 The block SHALL NOT alter rd=x0 requests.
REQ-033 o_err SHALL be 0 for every word of an LI request.

Reset
REQ-034 While i_rst=1, the FSM SHALL be forced to IDLE, with o_valid=0, o_err=0, o_last=0, o_instr=0 and o_ready=0.
REQ-035 o_ready SHALL be 1 in the first cycle after i_rst deasserts.
REQ-036 A reset during OUT or OUT2 SHALL discard the in-flight request, including any pending second word; no partial word may appear after reset.
REQ-037 A request presented during reset SHALL be ignored.

Verification
REQ-038 I-format scenario: fmt=1, opcode=0x13, f3=0, rd=1, rs1=0, imm=5 -> o_instr=0x00500093, o_err=0, o_last=1, one cycle after acceptance.
REQ-039 B-format scenario: fmt=3, opcode=0x63, f3=0, rs1=1, rs2=2, imm=-4 -> o_instr=0xFE208EE3.
REQ-040 LI scenario: fmt=6, rd=5, imm=0x12345FFF -> first word 0x123462B7 with o_last=0, then 0xFFF28293 with o_last=1.
REQ-041 Error scenario: fmt=5, imm=3 (odd) -> o_instr=0x00000013, o_err=1, o_last=1.
REQ-042 Backpressure scenario: i_ready=0 for 3 cycles during OUT -> o_instr and o_valid held constant and o_ready=0; the word transfers on the cycle i_ready rises.
REQ-043 Reset scenario: assert i_rst in OUT2 of the LI request from REQ-040 -> next cycle o_valid=0, the state is IDLE, and 0xFFF28293 is never emitted.
